// File: rtl/ahb_lite_arbiter.sv
// ahb_lite_arbiter: round-robin arbiter and bus multiplexer that shares one
// AHB-Lite slave port between NUM_M request/grant masters.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   m_req / m_gnt       per-master request in, registered one-hot grant out
//   m_haddr..m_hwdata   per-master address/control/write data, packed by master
//   m_hready            per-master ready (stall for non-owners that request)
//   m_hrdata, m_hresp   slave read data / response, broadcast to all masters
//   hsel..hwdata        slave-side address/control/write data
//   hrdata, hready, hresp  slave response
module ahb_lite_arbiter #(
  parameter int unsigned NUM_M      = 2,
  parameter int unsigned ADD_width  = 32,
  parameter int unsigned DATA_width = 32,
  parameter int unsigned RESP_width = 1,
  parameter int unsigned MAX_HOLD   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_M-1:0]              m_req,
  output logic [NUM_M-1:0]              m_gnt,
  input  logic [NUM_M*ADD_width-1:0]    m_haddr,
  input  logic [NUM_M*2-1:0]            m_htrans,
  input  logic [NUM_M-1:0]              m_hwrite,
  input  logic [NUM_M*3-1:0]            m_hsize,
  input  logic [NUM_M*3-1:0]            m_hburst,
  input  logic [NUM_M*4-1:0]            m_hprot,
  input  logic [NUM_M*DATA_width-1:0]   m_hwdata,
  output logic [NUM_M-1:0]              m_hready,
  output logic [DATA_width-1:0]         m_hrdata,
  output logic [RESP_width-1:0]         m_hresp,
  output logic                          hsel,
  output logic [ADD_width-1:0]          haddr,
  output logic [1:0]                    htrans,
  output logic                          hwrite,
  output logic [2:0]                    hsize,
  output logic [2:0]                    hburst,
  output logic [3:0]                    hprot,
  output logic [DATA_width-1:0]         hwdata,
  input  logic [DATA_width-1:0]         hrdata,
  input  logic                          hready,
  input  logic [RESP_width-1:0]         hresp
);

  localparam int unsigned IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  localparam logic [0:0] FREE  = 1'b0;
  localparam logic [0:0] OWNED = 1'b1;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [2:0] BURST_SINGLE = 3'b000;

  logic [0:0]       state, state_n;
  logic [IW-1:0]    addr_idx, addr_idx_n;
  logic             data_vld, data_vld_n;
  logic [IW-1:0]    data_idx, data_idx_n;
  logic [IW-1:0]    rr_last, rr_last_n;
  logic [HW-1:0]    hold_cnt, hold_cnt_n;
  logic [NUM_M-1:0] gnt_n;

  logic             own_req;
  logic [NUM_M-1:0] others_req;
  logic [IW:0]      pick_all, pick_oth;
  logic             rel_a, rel_b;

  // First requester strictly after 'last', wrapping; MSB of result = found.
  function automatic logic [IW:0] rr_pick(input logic [NUM_M-1:0] req,
                                          input logic [IW-1:0] last);
    logic          found;
    logic [IW-1:0] win;
    logic [IW-1:0] jj;
    int            j;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= int'(NUM_M); k++) begin
      j = int'(last) + k;
      if (j >= int'(NUM_M)) j = j - int'(NUM_M);
      jj = IW'(j);
      if (!found && req[jj]) begin
        found = 1'b1;
        win   = jj;
      end
    end
    return {found, win};
  endfunction

  // Address/control mux from the address-phase owner; idle bus when none.
  always_comb begin
    haddr   = '0;
    htrans  = TR_IDLE;
    hwrite  = 1'b0;
    hsize   = '0;
    hburst  = '0;
    hprot   = '0;
    own_req = 1'b0;
    for (int i = 0; i < int'(NUM_M); i++) begin
      if (state == OWNED && addr_idx == IW'(i)) begin
        haddr   = m_haddr[i*ADD_width +: ADD_width];
        htrans  = m_htrans[i*2 +: 2];
        hwrite  = m_hwrite[i];
        hsize   = m_hsize[i*3 +: 3];
        hburst  = m_hburst[i*3 +: 3];
        hprot   = m_hprot[i*4 +: 4];
        own_req = m_req[i];
      end
    end
    hsel = (state == OWNED) && htrans[1];
  end

  // Write data follows the data-phase owner, one beat behind the address.
  always_comb begin
    hwdata = '0;
    for (int i = 0; i < int'(NUM_M); i++) begin
      if (data_vld && data_idx == IW'(i)) hwdata = m_hwdata[i*DATA_width +: DATA_width];
    end
  end

  // Owners see the slave ready; waiting requesters are held off.
  always_comb begin
    m_hready = '1;
    if (!reset) begin
      for (int i = 0; i < int'(NUM_M); i++) begin
        if ((state == OWNED && addr_idx == IW'(i)) || (data_vld && data_idx == IW'(i)))
          m_hready[i] = hready;
        else
          m_hready[i] = ~m_req[i];
      end
    end
  end

  assign m_hrdata = hrdata;
  assign m_hresp  = hresp;

  // Next-state: arbitration, release and ownership tracking.
  always_comb begin
    state_n    = state;
    addr_idx_n = addr_idx;
    data_vld_n = data_vld;
    data_idx_n = data_idx;
    rr_last_n  = rr_last;
    hold_cnt_n = hold_cnt;
    gnt_n      = '0;

    others_req = m_req;
    if (state == OWNED) others_req[addr_idx] = 1'b0;
    pick_all = rr_pick(m_req, rr_last);
    pick_oth = rr_pick(others_req, rr_last);

    // Release only at a transfer boundary: never during SEQ or BUSY.
    rel_a = !own_req && (htrans == TR_IDLE);
    rel_b = (hold_cnt >= HW'(MAX_HOLD)) && (|others_req) &&
            ((htrans == TR_IDLE) || (htrans == TR_NONSEQ && hburst == BURST_SINGLE));

    if (hready) begin
      data_vld_n = (state == OWNED) && htrans[1];
      if ((state == OWNED) && htrans[1]) data_idx_n = addr_idx;

      case (state)
        FREE: begin
          if (pick_all[IW]) begin
            state_n    = OWNED;
            addr_idx_n = pick_all[IW-1:0];
            rr_last_n  = pick_all[IW-1:0];
            hold_cnt_n = '0;
          end
        end
        OWNED: begin
          if (htrans[1] && hold_cnt < HW'(MAX_HOLD)) hold_cnt_n = hold_cnt + HW'(1);
          if (rel_a || rel_b) begin
            hold_cnt_n = '0;
            if (pick_oth[IW]) begin
              // Direct handover, no dead cycle on the bus.
              addr_idx_n = pick_oth[IW-1:0];
              rr_last_n  = pick_oth[IW-1:0];
            end else begin
              state_n = FREE;
            end
          end
        end
        default: state_n = FREE;
      endcase
    end

    for (int i = 0; i < int'(NUM_M); i++) begin
      gnt_n[i] = (state_n == OWNED) && (addr_idx_n == IW'(i));
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FREE;
      addr_idx <= '0;
      data_vld <= 1'b0;
      data_idx <= '0;
      rr_last  <= IW'(NUM_M - 1);
      hold_cnt <= '0;
      m_gnt    <= '0;
    end else begin
      state    <= state_n;
      addr_idx <= addr_idx_n;
      data_vld <= data_vld_n;
      data_idx <= data_idx_n;
      rr_last  <= rr_last_n;
      hold_cnt <= hold_cnt_n;
      m_gnt    <= gnt_n;
    end
  end

endmodule
